menu_pointer_glide: RTL and testbench



---
 rtl/menu_pointer_glide.sv | 167 ++++++++++++++++
 tb/tb_menu_pointer_glide.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/menu_pointer_glide.sv
// Menu pointer position mapper with glide animation: maps menu state/counter to a
// pointer target and slides the registered position toward it within one screen.
module menu_pointer_glide #(
    parameter int unsigned COUNTER_W  = 3,
    parameter int unsigned MAIN_X     = 451,
    parameter int unsigned MAIN_Y0    = 228,
    parameter int unsigned MAIN_ITEMS = 4,
    parameter int unsigned EXIT_X     = 435,
    parameter int unsigned EXIT_Y0    = 244,
    parameter int unsigned EXIT_ITEMS = 2,
    parameter int unsigned PITCH      = 32,
    parameter int unsigned INFO_X     = 523,
    parameter int unsigned INFO_Y     = 340,
    parameter int unsigned HIDE_X     = 1024,
    parameter int unsigned HIDE_Y     = 0,
    parameter int unsigned STEP       = 4,
    parameter int unsigned TICK_DIV   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           menu_state,
    input  logic [COUNTER_W-1:0] menu_counter,
    output logic [10:0]          x_pointer,
    output logic [10:0]          y_pointer,
    output logic                 pointer_visible,
    output logic                 moving,
    output logic                 arrived
);

    localparam int unsigned POS_W  = 11;
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [POS_W-1:0]  MAIN_X_V  = POS_W'(MAIN_X);
    localparam logic [POS_W-1:0]  MAIN_Y0_V = POS_W'(MAIN_Y0);
    localparam logic [POS_W-1:0]  EXIT_X_V  = POS_W'(EXIT_X);
    localparam logic [POS_W-1:0]  EXIT_Y0_V = POS_W'(EXIT_Y0);
    localparam logic [POS_W-1:0]  PITCH_V   = POS_W'(PITCH);
    localparam logic [POS_W-1:0]  INFO_X_V  = POS_W'(INFO_X);
    localparam logic [POS_W-1:0]  INFO_Y_V  = POS_W'(INFO_Y);
    localparam logic [POS_W-1:0]  HIDE_X_V  = POS_W'(HIDE_X);
    localparam logic [POS_W-1:0]  HIDE_Y_V  = POS_W'(HIDE_Y);
    localparam logic [POS_W-1:0]  STEP_V    = POS_W'(STEP);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic {
        HOLD  = 1'b0,
        GLIDE = 1'b1
    } fsm_t;

    fsm_t              fsm_q, fsm_d;
    logic [POS_W-1:0]  x_q, x_d, y_q, y_d;
    logic [POS_W-1:0]  tgt_x, tgt_y;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        state_q;
    logic              visible_q, visible_d;
    logic              moving_q, moving_d;
    logic              arrived_q, arrived_d;
    logic              tgt_hide, pos_hide, at_tgt;

    // Move one axis toward its target, clamped so it never overshoots.
    function automatic logic [POS_W-1:0] approach(input logic [POS_W-1:0] cur,
                                                  input logic [POS_W-1:0] tgt);
        logic [POS_W-1:0] diff;
        if (cur < tgt) begin
            diff = tgt - cur;
            return cur + ((diff > STEP_V) ? STEP_V : diff);
        end else begin
            diff = cur - tgt;
            return cur - ((diff > STEP_V) ? STEP_V : diff);
        end
    endfunction

    // Layout lookup for the current menu screen and selection.
    always_comb begin
        tgt_x = HIDE_X_V;
        tgt_y = HIDE_Y_V;
        case (menu_state)
            3'd0: begin
                if (32'(menu_counter) < MAIN_ITEMS) begin
                    tgt_x = MAIN_X_V;
                    tgt_y = MAIN_Y0_V + POS_W'(menu_counter) * PITCH_V;
                end
            end
            3'd2, 3'd3: begin
                tgt_x = INFO_X_V;
                tgt_y = INFO_Y_V;
            end
            3'd4: begin
                if (32'(menu_counter) < EXIT_ITEMS) begin
                    tgt_x = EXIT_X_V;
                    tgt_y = EXIT_Y0_V + POS_W'(menu_counter) * PITCH_V;
                end
            end
            default: ;
        endcase
    end

    // Next-state and next-output logic for the HOLD/GLIDE controller.
    always_comb begin
        fsm_d     = fsm_q;
        x_d       = x_q;
        y_d       = y_q;
        tick_d    = tick_q;
        arrived_d = 1'b0;

        tgt_hide = (tgt_x == HIDE_X_V) && (tgt_y == HIDE_Y_V);
        pos_hide = (x_q == HIDE_X_V) && (y_q == HIDE_Y_V);
        at_tgt   = (x_q == tgt_x) && (y_q == tgt_y);

        if ((menu_state != state_q) || tgt_hide || pos_hide) begin
            x_d       = tgt_x;
            y_d       = tgt_y;
            fsm_d     = HOLD;
            arrived_d = !at_tgt;
        end else if (fsm_q == HOLD) begin
            if (!at_tgt) begin
                fsm_d  = GLIDE;
                tick_d = '0;
            end
        end else if (at_tgt) begin
            fsm_d     = HOLD;
            arrived_d = 1'b1;
        end else if (tick_q == TICK_LAST) begin
            tick_d = '0;
            x_d    = approach(x_q, tgt_x);
            y_d    = approach(y_q, tgt_y);
            if ((x_d == tgt_x) && (y_d == tgt_y)) begin
                fsm_d     = HOLD;
                arrived_d = 1'b1;
            end
        end else begin
            tick_d = tick_q + TICK_W'(1);
        end

        visible_d = !((x_d == HIDE_X_V) && (y_d == HIDE_Y_V));
        moving_d  = (fsm_d == GLIDE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= HOLD;
            x_q       <= HIDE_X_V;
            y_q       <= HIDE_Y_V;
            tick_q    <= '0;
            state_q   <= 3'd7;
            visible_q <= 1'b0;
            moving_q  <= 1'b0;
            arrived_q <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            x_q       <= x_d;
            y_q       <= y_d;
            tick_q    <= tick_d;
            state_q   <= menu_state;
            visible_q <= visible_d;
            moving_q  <= moving_d;
            arrived_q <= arrived_d;
        end
    end

    assign x_pointer       = x_q;
    assign y_pointer       = y_q;
    assign pointer_visible = visible_q;
    assign moving          = moving_q;
    assign arrived         = arrived_q;

endmodule

// File: tb/tb_menu_pointer_glide.sv
// Directed bench for menu_pointer_glide: jumps, glides, retargets and async reset
// against hand-computed positions with the default layout parameters.
module tb_menu_pointer_glide;

    logic        clk;
    logic        rst_n;
    logic [2:0]  menu_state;
    logic [2:0]  menu_counter;
    logic [10:0] x_pointer;
    logic [10:0] y_pointer;
    logic        pointer_visible;
    logic        moving;
    logic        arrived;

    int n_checks = 0;
    int n_errors = 0;
    int n_arrived;

    menu_pointer_glide dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .menu_state      (menu_state),
        .menu_counter    (menu_counter),
        .x_pointer       (x_pointer),
        .y_pointer       (y_pointer),
        .pointer_visible (pointer_visible),
        .moving          (moving),
        .arrived         (arrived)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic nedge();
        @(negedge clk);
    endtask

    task automatic check_pos(input string tag, input int x, input int y, input int vis,
                             input int mov, input int arr);
        check({tag, ".x"}, 32'(x_pointer), 32'(x));
        check({tag, ".y"}, 32'(y_pointer), 32'(y));
        check({tag, ".vis"}, 32'(pointer_visible), 32'(vis));
        check({tag, ".mov"}, 32'(moving), 32'(mov));
        check({tag, ".arr"}, 32'(arrived), 32'(arr));
    endtask

    initial begin
        rst_n        = 1'b0;
        menu_state   = 3'd0;
        menu_counter = 3'd0;

        // Reset and first jump onto Main item 0
        nedge(); nedge();
        check_pos("reset", 1024, 0, 0, 0, 0);
        rst_n = 1'b1;
        nedge();
        check_pos("first_jump", 451, 228, 1, 0, 1);
        nedge();
        check_pos("first_hold", 451, 228, 1, 0, 0);

        // Glide 0 -> 1: eight steps of 4, one every 2 cycles
        menu_counter = 3'd1;
        nedge();
        check_pos("glide_entry", 451, 228, 1, 1, 0);
        for (int k = 1; k <= 8; k++) begin
            nedge();
            check("glide_mid.y", 32'(y_pointer), 32'(228 + 4 * (k - 1)));
            nedge();
            check("glide_step.y", 32'(y_pointer), 32'(228 + 4 * k));
            check("glide_step.arr", 32'(arrived), (k == 8) ? 32'd1 : 32'd0);
            check("glide_step.mov", 32'(moving), (k == 8) ? 32'd0 : 32'd1);
        end
        nedge();
        check_pos("glide_done", 451, 260, 1, 0, 0);

        // Glide back down to item 0
        menu_counter = 3'd0;
        repeat (17) nedge();
        check_pos("glide_back", 451, 228, 1, 0, 1);

        // Retarget 1 -> 3 at y=240 without restarting the tick phase
        menu_counter = 3'd1;
        repeat (7) nedge();
        check_pos("pre_retarget", 451, 240, 1, 1, 0);
        menu_counter = 3'd3;
        n_arrived = 0;
        for (int j = 1; j <= 21; j++) begin
            nedge();
            if (arrived) n_arrived++;
            nedge();
            if (arrived) n_arrived++;
            check("retarget.y", 32'(y_pointer), 32'(240 + 4 * j));
        end
        nedge();
        if (arrived) n_arrived++;
        check("retarget.arr_count", 32'(n_arrived), 32'd1);
        check_pos("retarget_done", 451, 324, 1, 0, 0);

        // Screen change mid-glide jumps and ends the glide
        menu_counter = 3'd0;
        nedge(); nedge(); nedge();
        check_pos("pre_exit", 451, 320, 1, 1, 0);
        menu_state   = 3'd4;
        menu_counter = 3'd1;
        nedge();
        check_pos("exit_jump", 435, 276, 1, 0, 1);
        nedge();
        check_pos("exit_hold", 435, 276, 1, 0, 0);

        // Out-of-range item hides; valid item then jumps from hidden
        menu_state   = 3'd0;
        menu_counter = 3'd5;
        nedge();
        check_pos("main_hide", 1024, 0, 0, 0, 1);
        menu_counter = 3'd2;
        nedge();
        check_pos("unhide_jump", 451, 292, 1, 0, 1);

        // Info screens, StartGame and invalid state
        menu_state = 3'd3;
        nedge();
        check_pos("about", 523, 340, 1, 0, 1);
        menu_state = 3'd1;
        nedge();
        check_pos("start_game", 1024, 0, 0, 0, 1);
        menu_state = 3'd5;
        nedge();
        check_pos("invalid", 1024, 0, 0, 0, 0);

        // Async reset asserted between edges mid-glide
        menu_state   = 3'd0;
        menu_counter = 3'd0;
        nedge();
        check_pos("pre_rst_jump", 451, 228, 1, 0, 1);
        menu_counter = 3'd3;
        nedge();
        nedge(); nedge();
        check_pos("pre_rst_glide", 451, 232, 1, 1, 0);
        #3 rst_n = 1'b0;
        #1;
        check_pos("async_rst", 1024, 0, 0, 0, 0);
        nedge();
        menu_counter = 3'd0;
        rst_n        = 1'b1;
        nedge();
        check_pos("post_rst_jump", 451, 228, 1, 0, 1);
        nedge();
        check_pos("post_rst_hold", 451, 228, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
